// File: rtl/pdp8_pkg.sv
// pdp8 shared package: bus widths and memory arbiter state/source types.
// Optional build macro ARB_STARVE_GUARD_EN is consumed by pdp8_mem_arbiter.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_DONE
  } arb_state_e;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_IFU,
    SRC_EXU_RD,
    SRC_EXU_WR
  } arb_src_e;

  function automatic logic is_write(arb_src_e s);
    return s == SRC_EXU_WR;
  endfunction

endpackage

// File: rtl/pdp8_mem_arbiter_if.sv
// Requester and memory-side bundle of the pdp8 memory arbiter.
// slave = arbiter view, master = requesters plus memory array view.
interface pdp8_mem_arbiter_if #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH
);

  logic                  ifu_rd_req;
  logic [ADDR_WIDTH-1:0] ifu_rd_addr;
  logic [DATA_WIDTH-1:0] ifu_rd_data;
  logic                  ifu_rd_valid;

  logic                  exu_rd_req;
  logic [ADDR_WIDTH-1:0] exu_rd_addr;
  logic [DATA_WIDTH-1:0] exu_rd_data;
  logic                  exu_rd_valid;

  logic                  exu_wr_req;
  logic [ADDR_WIDTH-1:0] exu_wr_addr;
  logic [DATA_WIDTH-1:0] exu_wr_data;
  logic                  exu_wr_done;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  modport slave (
    input  ifu_rd_req, ifu_rd_addr,
    output ifu_rd_data, ifu_rd_valid,
    input  exu_rd_req, exu_rd_addr,
    output exu_rd_data, exu_rd_valid,
    input  exu_wr_req, exu_wr_addr, exu_wr_data,
    output exu_wr_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output ifu_rd_req, ifu_rd_addr,
    input  ifu_rd_data, ifu_rd_valid,
    output exu_rd_req, exu_rd_addr,
    input  exu_rd_data, exu_rd_valid,
    output exu_wr_req, exu_wr_addr, exu_wr_data,
    input  exu_wr_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/pdp8_arb_prio.sv
// Combinational request picker: EXU write > EXU read > IFU read,
// unless the starve flag forces a pending IFU read to win.
module pdp8_arb_prio
  import pdp8_pkg::*;
(
  input  logic     ifu_rd_req,
  input  logic     exu_rd_req,
  input  logic     exu_wr_req,
  input  logic     starve,
  output arb_src_e src
);

  logic force_ifu;
  logic wr_win;
  logic rd_win;
  logic ifu_win;

  // Terms are made mutually exclusive so the decoder is truly unique.
  assign force_ifu = starve & ifu_rd_req;
  assign wr_win    = exu_wr_req & ~force_ifu;
  assign rd_win    = exu_rd_req & ~exu_wr_req & ~force_ifu;
  assign ifu_win   = ifu_rd_req &
                     (force_ifu | (~exu_wr_req & ~exu_rd_req));

  always_comb begin
    src = SRC_NONE;
    unique case (1'b1)
      wr_win:  src = SRC_EXU_WR;
      rd_win:  src = SRC_EXU_RD;
      ifu_win: src = SRC_IFU;
      default: src = SRC_NONE;
    endcase
  end

endmodule

// File: rtl/pdp8_mem_arbiter.sv
// Single-port memory arbiter for IFU reads and EXU reads/writes.
// Define ARB_STARVE_GUARD_EN to bound IFU fetch delay (STARVE_LIMIT).
module pdp8_mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int ADDR_WIDTH   = `ADDR_WIDTH,
  parameter int DATA_WIDTH   = `DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  pdp8_mem_arbiter_if.slave bus
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  arb_state_e state;
  arb_src_e   src_q;
  arb_src_e   pick;
  logic       starve;

  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] ifu_data_q;
  logic [DATA_WIDTH-1:0] exu_data_q;
  logic                  ifu_vld_q;
  logic                  exu_vld_q;
  logic                  wr_done_q;
  logic                  busy_q;

  pdp8_arb_prio u_prio (
    .ifu_rd_req (bus.ifu_rd_req),
    .exu_rd_req (bus.exu_rd_req),
    .exu_wr_req (bus.exu_wr_req),
    .starve     (starve),
    .src        (pick)
  );

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  assign starve = (starve_cnt == LIMIT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (state == ARB_IDLE) begin
      if (pick == SRC_IFU)
        starve_cnt <= '0;
      else if (bus.ifu_rd_req && !starve)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ARB_IDLE;
      src_q       <= SRC_NONE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ifu_data_q  <= '0;
      exu_data_q  <= '0;
      ifu_vld_q   <= 1'b0;
      exu_vld_q   <= 1'b0;
      wr_done_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ifu_vld_q <= 1'b0;
      exu_vld_q <= 1'b0;
      wr_done_q <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (pick != SRC_NONE) begin
            state       <= ARB_ISSUE;
            src_q       <= pick;
            busy_q      <= 1'b1;
            mem_en_q    <= 1'b1;
            mem_we_q    <= is_write(pick);
            mem_wdata_q <= bus.exu_wr_data;
            unique case (pick)
              SRC_EXU_WR: mem_addr_q <= bus.exu_wr_addr;
              SRC_EXU_RD: mem_addr_q <= bus.exu_rd_addr;
              default:    mem_addr_q <= bus.ifu_rd_addr;
            endcase
          end
        end
        ARB_ISSUE: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          if (is_write(src_q)) begin
            state     <= ARB_DONE;
            wr_done_q <= 1'b1;
          end else begin
            state <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          state <= ARB_DONE;
          if (src_q == SRC_IFU) begin
            ifu_data_q <= bus.mem_rdata;
            ifu_vld_q  <= 1'b1;
          end else begin
            exu_data_q <= bus.mem_rdata;
            exu_vld_q  <= 1'b1;
          end
        end
        ARB_DONE: begin
          state  <= ARB_IDLE;
          src_q  <= SRC_NONE;
          busy_q <= 1'b0;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign bus.mem_en       = mem_en_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.ifu_rd_data  = ifu_data_q;
  assign bus.ifu_rd_valid = ifu_vld_q;
  assign bus.exu_rd_data  = exu_data_q;
  assign bus.exu_rd_valid = exu_vld_q;
  assign bus.exu_wr_done  = wr_done_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
// Directed bench for pdp8_mem_arbiter with a synchronous memory model.
// Starvation expectations follow ARB_STARVE_GUARD_EN.
module tb_pdp8_mem_arbiter;
  import pdp8_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] mem [0:4095];

  pdp8_mem_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(12)) bus ();

  pdp8_mem_arbiter #(
    .ADDR_WIDTH   (12),
    .DATA_WIDTH   (12),
    .STARVE_LIMIT (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 = IFU read, 1 = EXU read, 2 = EXU write
  task automatic access(input string tag, input int kind,
                        input logic [11:0] a, input logic [11:0] d,
                        input logic [11:0] exp);
    int lat;
    logic hit;
    case (kind)
      0: begin bus.ifu_rd_addr = a; bus.ifu_rd_req = 1'b1; end
      1: begin bus.exu_rd_addr = a; bus.exu_rd_req = 1'b1; end
      default: begin
        bus.exu_wr_addr = a;
        bus.exu_wr_data = d;
        bus.exu_wr_req  = 1'b1;
      end
    endcase
    lat = 0;
    hit = 1'b0;
    while (!hit && lat < 16) begin
      tick();
      lat++;
      hit = (kind == 0) ? bus.ifu_rd_valid :
            (kind == 1) ? bus.exu_rd_valid : bus.exu_wr_done;
    end
    bus.ifu_rd_req = 1'b0;
    bus.exu_rd_req = 1'b0;
    bus.exu_wr_req = 1'b0;
    check({tag, ".lat"}, lat, (kind == 2) ? 2 : 3);
    if (kind == 0) check({tag, ".data"}, bus.ifu_rd_data, exp);
    if (kind == 1) check({tag, ".data"}, bus.exu_rd_data, exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_wr, t_rd, t_ifu, overlap, arb, first_ifu, lat;
    logic [11:0] ifu_d, exu_d;
    for (int i = 0; i < 4096; i++) mem[i] = 12'o0;
    mem[12'o0200] = 12'o1234;
    bus.ifu_rd_req  = 1'b0;
    bus.ifu_rd_addr = '0;
    bus.exu_rd_req  = 1'b0;
    bus.exu_rd_addr = '0;
    bus.exu_wr_req  = 1'b0;
    bus.exu_wr_addr = '0;
    bus.exu_wr_data = '0;
    bus.mem_rdata   = '0;

    repeat (3) tick();
    check("rst.mem_en", bus.mem_en, 0);
    check("rst.busy", bus.busy, 0);
    check("rst.ifu_vld", bus.ifu_rd_valid, 0);
    check("rst.ifu_data", bus.ifu_rd_data, 0);
    check("rst.mem_addr", bus.mem_addr, 0);
    reset_n = 1'b1;
    tick();

    // IFU read of 0200, cycle by cycle
    bus.ifu_rd_addr = 12'o0200;
    bus.ifu_rd_req  = 1'b1;
    tick();
    check("t1.en", bus.mem_en, 1);
    check("t1.we", bus.mem_we, 0);
    check("t1.addr", bus.mem_addr, 12'o0200);
    check("t1.busy", bus.busy, 1);
    bus.ifu_rd_addr = 12'o0777;
    tick();
    check("t1.en2", bus.mem_en, 0);
    check("t1.vld2", bus.ifu_rd_valid, 0);
    tick();
    check("t1.vld", bus.ifu_rd_valid, 1);
    check("t1.data", bus.ifu_rd_data, 12'o1234);
    check("t1.busy3", bus.busy, 1);
    bus.ifu_rd_req = 1'b0;
    tick();
    check("t1.vld_off", bus.ifu_rd_valid, 0);
    check("t1.idle", bus.busy, 0);
    check("t1.hold", bus.ifu_rd_data, 12'o1234);

    // EXU write 7777 to 0050, cycle by cycle
    bus.exu_wr_addr = 12'o0050;
    bus.exu_wr_data = 12'o7777;
    bus.exu_wr_req  = 1'b1;
    tick();
    check("t2.en", bus.mem_en, 1);
    check("t2.we", bus.mem_we, 1);
    check("t2.addr", bus.mem_addr, 12'o0050);
    check("t2.wdata", bus.mem_wdata, 12'o7777);
    tick();
    check("t2.done", bus.exu_wr_done, 1);
    check("t2.en_off", bus.mem_en, 0);
    bus.exu_wr_req = 1'b0;
    tick();
    check("t2.done_off", bus.exu_wr_done, 0);
    check("t2.idle", bus.busy, 0);
    access("t2.ifu_rd", 0, 12'o0050, 12'o0, 12'o7777);
    access("t2.exu_rd", 1, 12'o0200, 12'o0, 12'o1234);
    check("t2.ifu_hold", bus.ifu_rd_data, 12'o7777);
    access("t2.wr_top", 2, 12'o7777, 12'o0001, 12'o0);
    access("t2.rd_top", 0, 12'o7777, 12'o0, 12'o0001);

    // All three requesters in the same cycle
    bus.ifu_rd_addr = 12'o0200;
    bus.exu_rd_addr = 12'o0300;
    bus.exu_wr_addr = 12'o0300;
    bus.exu_wr_data = 12'o4321;
    bus.ifu_rd_req  = 1'b1;
    bus.exu_rd_req  = 1'b1;
    bus.exu_wr_req  = 1'b1;
    t_wr = 0; t_rd = 0; t_ifu = 0; overlap = 0;
    ifu_d = '0; exu_d = '0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (int'(bus.exu_wr_done) + int'(bus.exu_rd_valid) +
          int'(bus.ifu_rd_valid) > 1) overlap++;
      if (bus.exu_wr_done) begin t_wr = c; bus.exu_wr_req = 1'b0; end
      if (bus.exu_rd_valid) begin
        t_rd = c; exu_d = bus.exu_rd_data; bus.exu_rd_req = 1'b0;
      end
      if (bus.ifu_rd_valid) begin
        t_ifu = c; ifu_d = bus.ifu_rd_data; bus.ifu_rd_req = 1'b0;
      end
    end
    check("t3.wr_cyc", t_wr, 2);
    check("t3.rd_cyc", t_rd, 6);
    check("t3.ifu_cyc", t_ifu, 10);
    check("t3.overlap", overlap, 0);
    check("t3.exu_data", exu_d, 12'o4321);
    check("t3.ifu_data", ifu_d, 12'o1234);
    check("t3.idle", bus.busy, 0);

    // EXU reads back to back while IFU keeps requesting
    bus.ifu_rd_addr = 12'o0200;
    bus.exu_rd_addr = 12'o0300;
    bus.ifu_rd_req  = 1'b1;
    bus.exu_rd_req  = 1'b1;
    arb = 0; first_ifu = 0;
    for (int c = 0; c < 60 && arb < 8; c++) begin
      tick();
      if (bus.mem_en) begin
        arb++;
        if (bus.mem_addr == 12'o0200 && first_ifu == 0) first_ifu = arb;
      end
      if (bus.ifu_rd_valid) bus.ifu_rd_req = 1'b0;
    end
    bus.ifu_rd_req = 1'b0;
    bus.exu_rd_req = 1'b0;
    check("t4.arbs", arb, 8);
`ifdef ARB_STARVE_GUARD_EN
    check("t4.ifu_grant", first_ifu, 5);
`else
    check("t4.ifu_grant", first_ifu, 0);
`endif
    for (int c = 0; c < 10 && bus.busy; c++) tick();
    tick();
    check("t4.idle", bus.busy, 0);

    // Reset during ISSUE drops mem_en at once
    bus.ifu_rd_addr = 12'o0200;
    bus.ifu_rd_req  = 1'b1;
    tick();
    check("t5.issue_en", bus.mem_en, 1);
    reset_n = 1'b0;
    #1;
    check("t5.rst_en", bus.mem_en, 0);
    check("t5.rst_busy", bus.busy, 0);
    tick();
    reset_n = 1'b1;

    // Reset during WAIT of an IFU read, request held throughout
    tick();
    tick();
    check("t6.wait_busy", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    check("t6.rst_en", bus.mem_en, 0);
    check("t6.rst_busy", bus.busy, 0);
    check("t6.rst_data", bus.ifu_rd_data, 0);
    tick();
    check("t6.no_vld", bus.ifu_rd_valid, 0);
    reset_n = 1'b1;
    lat = 0;
    while (!bus.ifu_rd_valid && lat < 16) begin
      tick();
      lat++;
    end
    check("t6.lat", lat, 3);
    check("t6.data", bus.ifu_rd_data, 12'o1234);
    bus.ifu_rd_req = 1'b0;
    tick();
    check("t6.idle", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
